// File: rtl/enemy_controller_if.sv
// Command/status bundle between the software-facing interface block and one enemy slot.
// master drives commands and reads status; slave is the enemy_controller.
interface enemy_controller_if;
  logic       frame_tick;
  logic [2:0] dir;
  logic       spawn;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [1:0] spawn_type;
  logic [1:0] spawn_hp;
  logic       hit;
  logic [9:0] Enemy_X;
  logic [9:0] Enemy_Y;
  logic       Enemy_Active;
  logic [1:0] Enemy_Type;
  logic [2:0] Enemy_Facing;
  logic       Enemy_Visible;
  logic       spawn_ack;

  modport master (
    output frame_tick, dir, spawn, spawn_x, spawn_y, spawn_type, spawn_hp, hit,
    input  Enemy_X, Enemy_Y, Enemy_Active, Enemy_Type, Enemy_Facing, Enemy_Visible, spawn_ack
  );

  modport slave (
    input  frame_tick, dir, spawn, spawn_x, spawn_y, spawn_type, spawn_hp, hit,
    output Enemy_X, Enemy_Y, Enemy_Active, Enemy_Type, Enemy_Facing, Enemy_Visible, spawn_ack
  );
endinterface

// File: rtl/enemy_controller.sv
// Per-enemy motion and life-cycle engine; position/state advance once per frame_tick.
//
// state    | meaning
// INACTIVE | slot free, waiting for spawn
// ALIVE    | moves on dir each frame, collidable
// HURT     | knocked back opposite Facing, invulnerable, flickers
// DYING    | frozen death animation, then back to INACTIVE
module enemy_controller #(
  parameter logic [9:0] START_X      = 10'd0,
  parameter logic [9:0] START_Y      = 10'd0,
  parameter logic [9:0] STEP         = 10'd1,
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd623,
  parameter logic [9:0] Y_MIN        = 10'd0,
  parameter logic [9:0] Y_MAX        = 10'd463,
  parameter logic [3:0] HURT_FRAMES  = 4'd8,
  parameter logic [4:0] DYING_FRAMES = 5'd16
) (
  input  logic               clk,
  input  logic               reset,
  enemy_controller_if.slave  bus
);

  typedef enum logic [1:0] {INACTIVE, ALIVE, HURT, DYING} state_t;

  state_t     state, state_nxt;
  logic [9:0] x_q, x_nxt, y_q, y_nxt;
  logic [2:0] face_q, face_nxt;
  logic [1:0] type_q, type_nxt;
  logic [1:0] hp_q, hp_nxt;
  logic [4:0] cnt_q, cnt_nxt;
  logic       ack_q, ack_nxt;
  logic       move_en;
  logic [2:0] move_dir;

  // 11-bit compares so the bound +/- STEP never wraps
  function automatic logic [9:0] dec_clamp(input logic [9:0] v, input logic [9:0] lo);
    logic [10:0] lim;
    lim = {1'b0, lo} + {1'b0, STEP};
    if ({1'b0, v} < lim) return lo;
    return v - STEP;
  endfunction

  function automatic logic [9:0] inc_clamp(input logic [9:0] v, input logic [9:0] hi);
    logic [10:0] sum;
    sum = {1'b0, v} + {1'b0, STEP};
    if (sum > {1'b0, hi}) return hi;
    return sum[9:0];
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lo,
                                       input logic [9:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'd1:    return 3'd2;
      3'd2:    return 3'd1;
      3'd3:    return 3'd4;
      3'd4:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INACTIVE;
      x_q    <= START_X;
      y_q    <= START_Y;
      face_q <= 3'd2;
      type_q <= 2'd0;
      hp_q   <= 2'd0;
      cnt_q  <= 5'd0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      face_q <= face_nxt;
      type_q <= type_nxt;
      hp_q   <= hp_nxt;
      cnt_q  <= cnt_nxt;
      ack_q  <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    face_nxt  = face_q;
    type_nxt  = type_q;
    hp_nxt    = hp_q;
    cnt_nxt   = cnt_q;
    ack_nxt   = 1'b0;
    move_en   = 1'b0;
    move_dir  = 3'd0;

    case (state)
      INACTIVE: begin
        if (bus.spawn) begin
          x_nxt     = clamp(bus.spawn_x, X_MIN, X_MAX);
          y_nxt     = clamp(bus.spawn_y, Y_MIN, Y_MAX);
          type_nxt  = bus.spawn_type;
          hp_nxt    = (bus.spawn_hp == 2'd0) ? 2'd1 : bus.spawn_hp;
          face_nxt  = 3'd2;
          ack_nxt   = 1'b1;
          state_nxt = ALIVE;
        end
      end
      ALIVE: begin
        // hit outranks a coincident frame_tick: no move that cycle
        if (bus.hit) begin
          hp_nxt = hp_q - 2'd1;
          if (hp_q <= 2'd1) begin
            state_nxt = DYING;
            cnt_nxt   = DYING_FRAMES - 5'd1;
          end else begin
            state_nxt = HURT;
            cnt_nxt   = {1'b0, HURT_FRAMES - 4'd1};
          end
        end else if (bus.frame_tick && bus.dir >= 3'd1 && bus.dir <= 3'd4) begin
          move_en  = 1'b1;
          move_dir = bus.dir;
          face_nxt = bus.dir;
        end
      end
      HURT: begin
        if (bus.frame_tick) begin
          move_en  = 1'b1;
          move_dir = opposite(face_q);
          if (cnt_q == 5'd0) state_nxt = ALIVE;
          else               cnt_nxt   = cnt_q - 5'd1;
        end
      end
      DYING: begin
        if (bus.frame_tick) begin
          if (cnt_q == 5'd0) state_nxt = INACTIVE;
          else               cnt_nxt   = cnt_q - 5'd1;
        end
      end
      default: state_nxt = INACTIVE;
    endcase

    if (move_en) begin
      case (move_dir)
        3'd1:    y_nxt = dec_clamp(y_q, Y_MIN);
        3'd2:    y_nxt = inc_clamp(y_q, Y_MAX);
        3'd3:    x_nxt = dec_clamp(x_q, X_MIN);
        3'd4:    x_nxt = inc_clamp(x_q, X_MAX);
        default: ;
      endcase
    end
  end

  assign bus.Enemy_X       = x_q;
  assign bus.Enemy_Y       = y_q;
  assign bus.Enemy_Type    = type_q;
  assign bus.Enemy_Facing  = face_q;
  assign bus.spawn_ack     = ack_q;
  assign bus.Enemy_Active  = (state == ALIVE) || (state == HURT);
  assign bus.Enemy_Visible = (state == ALIVE) ? 1'b1 :
                             ((state == HURT) || (state == DYING)) ? cnt_q[1] : 1'b0;

endmodule

// File: tb/tb_enemy_controller.sv
// Bench for enemy_controller: directed scenarios with literal expectations, then random
// stimulus, all compared each cycle against a rule-level model of one enemy.
module tb_enemy_controller;
  localparam int STEP = 1, X_MIN = 0, X_MAX = 623, Y_MIN = 0, Y_MAX = 463;
  localparam int HURT_FRAMES = 8, DYING_FRAMES = 16, START_X = 0, START_Y = 0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  enemy_controller_if bus ();

  enemy_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // model: 0 free, 1 alive, 2 hurt, 3 dying
  int m_mode, m_x, m_y, m_face, m_type, m_hp, m_frames_left, m_ack;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_move(input int d);
    case (d)
      1: m_y = (m_y - STEP < Y_MIN) ? Y_MIN : m_y - STEP;
      2: m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
      3: m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
      4: m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_x = START_X; m_y = START_Y; m_face = 2; m_type = 0;
      m_hp = 0; m_frames_left = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (m_mode == 0) begin
        if (bus.spawn) begin
          m_x = int'(bus.spawn_x); m_y = int'(bus.spawn_y);
          if (m_x < X_MIN) m_x = X_MIN;
          if (m_x > X_MAX) m_x = X_MAX;
          if (m_y < Y_MIN) m_y = Y_MIN;
          if (m_y > Y_MAX) m_y = Y_MAX;
          m_type = int'(bus.spawn_type);
          m_hp   = (bus.spawn_hp == 0) ? 1 : int'(bus.spawn_hp);
          m_face = 2; m_mode = 1; m_ack = 1;
        end
      end else if (m_mode == 1) begin
        if (bus.hit) begin
          m_hp = m_hp - 1;
          if (m_hp == 0) begin m_mode = 3; m_frames_left = DYING_FRAMES - 1; end
          else           begin m_mode = 2; m_frames_left = HURT_FRAMES - 1; end
        end else if (bus.frame_tick && bus.dir >= 1 && bus.dir <= 4) begin
          model_move(int'(bus.dir));
          m_face = int'(bus.dir);
        end
      end else if (m_mode == 2) begin
        if (bus.frame_tick) begin
          // knockback: 1<->2, 3<->4
          model_move((m_face == 1) ? 2 : (m_face == 2) ? 1 : (m_face == 3) ? 4 : 3);
          if (m_frames_left == 0) m_mode = 1; else m_frames_left--;
        end
      end else begin
        if (bus.frame_tick) begin
          if (m_frames_left == 0) m_mode = 0; else m_frames_left--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("x", int'(bus.Enemy_X), m_x);
      cmp("y", int'(bus.Enemy_Y), m_y);
      cmp("active", int'(bus.Enemy_Active), (m_mode == 1 || m_mode == 2) ? 1 : 0);
      cmp("type", int'(bus.Enemy_Type), m_type);
      cmp("facing", int'(bus.Enemy_Facing), m_face);
      cmp("visible", int'(bus.Enemy_Visible),
          (m_mode == 1) ? 1 : (m_mode == 0) ? 0 : ((m_frames_left / 2) % 2));
      cmp("spawn_ack", int'(bus.spawn_ack), m_ack);
    end
  end

  task automatic do_reset();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_spawn(input int x, input int y, input int t, input int h);
    bus.spawn = 1'b1; bus.spawn_x = 10'(x); bus.spawn_y = 10'(y);
    bus.spawn_type = 2'(t); bus.spawn_hp = 2'(h);
    @(negedge clk);
    bus.spawn = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1; @(negedge clk);
      bus.frame_tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic do_hit(input bit with_tick);
    bus.hit = 1'b1; bus.frame_tick = with_tick;
    @(negedge clk);
    bus.hit = 1'b0; bus.frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 0; bus.dir = 0; bus.spawn = 0; bus.spawn_x = 0; bus.spawn_y = 0;
    bus.spawn_type = 0; bus.spawn_hp = 0; bus.hit = 0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    cmp("rst_x", int'(bus.Enemy_X), 0);
    cmp("rst_facing", int'(bus.Enemy_Facing), 2);
    cmp("rst_active", int'(bus.Enemy_Active), 0);
    cmp("rst_visible", int'(bus.Enemy_Visible), 0);
    reset = 1'b0;

    do_spawn(100, 200, 2, 2);
    cmp("sp_ack", int'(bus.spawn_ack), 1);
    cmp("sp_x", int'(bus.Enemy_X), 100);
    cmp("sp_y", int'(bus.Enemy_Y), 200);
    cmp("sp_type", int'(bus.Enemy_Type), 2);
    cmp("sp_vis", int'(bus.Enemy_Visible), 1);
    @(negedge clk);
    cmp("sp_ack_once", int'(bus.spawn_ack), 0);

    bus.dir = 4; ticks(3);
    cmp("right3_x", int'(bus.Enemy_X), 103);
    cmp("right3_face", int'(bus.Enemy_Facing), 4);
    bus.dir = 0; ticks(2);
    cmp("stop_x", int'(bus.Enemy_X), 103);
    cmp("stop_face", int'(bus.Enemy_Facing), 4);

    do_reset();
    do_spawn(49, 10, 1, 3);
    bus.dir = 4; ticks(1); bus.dir = 0;
    cmp("pre_hit_x", int'(bus.Enemy_X), 50);
    do_hit(0);
    cmp("hurt_active", int'(bus.Enemy_Active), 1);
    do_hit(0);
    ticks(8);
    cmp("knock_x", int'(bus.Enemy_X), 42);
    cmp("recover_vis", int'(bus.Enemy_Visible), 1);
    do_hit(0);
    cmp("hp_kept_active", int'(bus.Enemy_Active), 1);
    ticks(8);
    cmp("knock2_x", int'(bus.Enemy_X), 34);
    do_hit(1);
    cmp("dying_active", int'(bus.Enemy_Active), 0);
    cmp("dying_x", int'(bus.Enemy_X), 34);
    do_spawn(5, 5, 0, 1);
    cmp("dying_no_ack", int'(bus.spawn_ack), 0);
    ticks(16);
    cmp("dead_vis", int'(bus.Enemy_Visible), 0);
    do_spawn(622, 1, 3, 1);
    cmp("respawn_ack", int'(bus.spawn_ack), 1);
    bus.dir = 4; ticks(1);
    cmp("xmax_x", int'(bus.Enemy_X), 623);
    ticks(1);
    cmp("xmax_hold", int'(bus.Enemy_X), 623);
    bus.dir = 1; ticks(2);
    cmp("ymin_y", int'(bus.Enemy_Y), 0);
    bus.dir = 0;

    do_reset();
    do_spawn(1000, 900, 0, 0);
    cmp("clamp_x", int'(bus.Enemy_X), 623);
    cmp("clamp_y", int'(bus.Enemy_Y), 463);
    do_hit(0);
    cmp("hp0_dying", int'(bus.Enemy_Active), 0);

    do_reset();
    do_spawn(300, 300, 1, 2);
    do_hit(0);
    ticks(2);
    do_reset();
    cmp("midhurt_x", int'(bus.Enemy_X), 0);
    cmp("midhurt_y", int'(bus.Enemy_Y), 0);
    cmp("midhurt_active", int'(bus.Enemy_Active), 0);
    cmp("midhurt_face", int'(bus.Enemy_Facing), 2);

    repeat (4000) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.dir        = 3'($urandom_range(0, 7));
      bus.spawn      = ($urandom_range(0, 7) == 0);
      bus.spawn_x    = 10'($urandom_range(0, 1023));
      bus.spawn_y    = 10'($urandom_range(0, 1023));
      bus.spawn_type = 2'($urandom_range(0, 3));
      bus.spawn_hp   = 2'($urandom_range(0, 3));
      bus.hit        = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    reset = 1'b0; bus.frame_tick = 0; bus.spawn = 0; bus.hit = 0;
    @(negedge clk);
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_controller.md
# enemy_controller

Per-enemy motion and life-cycle engine: the entity-side endpoint of the NIOS↔entity interface. It consumes the 3-bit direction command that software writes for one enemy. It produces that enemy's X/Y position, Active flag and Type, which software reads back through the interface block. One instance per enemy slot (five in the top level); state advances once per video frame.

## Interface

Parameters:

- START_X, 10'd0: X loaded on reset.
- START_Y, 10'd0: Y loaded on reset.
- STEP, 10'd1: pixels moved per frame.
- X_MIN, 10'd0: inclusive lower X bound.
- X_MAX, 10'd623: inclusive upper X bound (640 − 16-pixel sprite − 1).
- Y_MIN, 10'd0: inclusive lower Y bound.
- Y_MAX, 10'd463: inclusive upper Y bound.
- HURT_FRAMES, 4'd8: knockback/invulnerable frames.
- DYING_FRAMES, 5'd16: death-animation frames.

Ports:

- clk, in, 1: system clock. Only clock.
- reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per vsync.
- dir, in, 3: direction command (0 stop, 1 up, 2 down, 3 left, 4 right, 5–7 treated as stop).
- spawn, in, 1: one-cycle spawn request.
- spawn_x, in, 10: spawn X.
- spawn_y, in, 10: spawn Y.
- spawn_type, in, 2: spawn type.
- spawn_hp, in, 2: spawn hit points; 0 is treated as 1.
- hit, in, 1: one-cycle damage pulse from the collision logic.
- Enemy_X, out, 10: position X.
- Enemy_Y, out, 10: position Y.
- Enemy_Active, out, 1: collidable and alive.
- Enemy_Type, out, 2: type.
- Enemy_Facing, out, 3: last non-stop direction.
- Enemy_Visible, out, 1: sprite draw enable.
- spawn_ack, out, 1: one-cycle pulse when a spawn is accepted.

## Operation

States: INACTIVE, ALIVE, HURT, DYING. Reset state is INACTIVE.

Reset values:
- Enemy_X = START_X, Enemy_Y = START_Y.
- Enemy_Active = 0, Enemy_Type = 0, Enemy_Facing = 2, Enemy_Visible = 0, spawn_ack = 0.
- hp = 0, frame counter = 0.

INACTIVE:
- spawn loads X/Y/Type/hp, sets Facing = 2, goes to ALIVE and pulses spawn_ack.
- hit and frame_tick are ignored.

ALIVE:
- On frame_tick with dir 1–4: move by STEP and set Facing = dir.
- dir stop/5–7: position and Facing hold.
- hit: decrement hp.
  - If the result is 0: go to DYING, counter = DYING_FRAMES − 1.
  - Otherwise: go to HURT, counter = HURT_FRAMES − 1.

HURT:
- dir is ignored. Each frame_tick moves STEP opposite to Facing (knockback); Facing does not change.
- hit is ignored (invulnerable).
- Each frame_tick decrements the counter; when the counter is 0 on a frame_tick, return to ALIVE.

DYING:
- Position frozen; hit ignored.
- Counter decrements per frame_tick; at 0 on a frame_tick, go to INACTIVE.

spawn is honoured only in INACTIVE. In all other states it is ignored and spawn_ack stays 0.

Outputs:
- Enemy_Active = 1 in ALIVE and HURT only.
- Enemy_Visible:
  - 1 in ALIVE.
  - In HURT and DYING, equals bit 1 of the counter (flicker).
  - 0 in INACTIVE.

Arithmetic is 10-bit unsigned with saturating clamps, never wrapping:
- Up: Y = (Y < Y_MIN + STEP) ? Y_MIN : Y − STEP.
- Down: Y = (Y > Y_MAX − STEP) ? Y_MAX : Y + STEP.
- Left/right: same rules on X with X_MIN/X_MAX.

Spawn coordinates outside the bounds are clamped into the bounds on load.

## Timing

- All outputs are registered. State, position and Facing update on the clk edge that samples frame_tick/hit/spawn, so outputs are visible the next cycle.
- spawn_ack is asserted the cycle after spawn is sampled, for exactly one cycle.
- dir is sampled only on frame_tick cycles; changes between ticks have no effect.
- hit and frame_tick in the same cycle (ALIVE): the hit transition wins and no movement occurs that cycle.
- spawn and hit in the same cycle (INACTIVE): the spawn is taken and the hit is ignored.
- reset asserted in any state returns all registers to reset values on the next edge, overriding frame_tick/hit/spawn in that cycle.
- Throughput: at most one move per frame_tick, one hp decrement per hit pulse.

## Test plan

- Reset, then spawn(x=100, y=200, type=2, hp=2) → next cycle spawn_ack=1, Active=1, X=100, Y=200, Type=2, Visible=1.
- ALIVE at X=100, dir=4, 3 frame_ticks with STEP=1 → X=103, Facing=4. Then dir=0 plus 2 ticks → X=103, Facing=4.
- Y=1, STEP=2, dir=1, one tick → Y=0 (clamp). X=622, dir=4 → X=623 (X_MAX), no wrap.
- hp=2, hit while Facing=4 at X=50 → HURT, Active=1; 8 ticks → X=42 and back to ALIVE. A second hit during HURT → hp unchanged.
- hp=1, hit and frame_tick in the same cycle → DYING, position unchanged, Active=0. 16 ticks → INACTIVE, Visible=0. spawn while DYING → no ack.
- reset asserted mid-HURT → next cycle state INACTIVE, X=START_X, Y=START_Y, Active=0, Facing=2.
